// File: rtl/riscv_exu_issue.sv
// Issue/write-back stage for a single-cycle ALU: instruction FIFO, 32x32 regfile with
// write-back bypass, one instruction in flight, watchdog on missing completions.
module riscv_exu_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [7:0]  in_tag,
  output logic        issue_vld,
  output logic [4:0]  issue_rd,
  output logic [7:0]  issue_tag,
  output logic [31:0] issue_rs1_data,
  output logic [31:0] issue_rs2_data,
  input  logic        done,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        busy,
  output logic [31:0] retired_count,
  output logic        err,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [7:0] tag;
  } entry_t;

  state_t          r_state, w_state_nxt;
  entry_t          r_q [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [WW-1:0]   r_wdog, w_wdog_nxt;
  logic [31:0]     r_regs [32];
  logic            r_issue_vld;
  logic [4:0]      r_issue_rd;
  logic [7:0]      r_issue_tag;
  logic [31:0]     r_issue_rs1, r_issue_rs2;
  logic [31:0]     r_retired;
  logic            r_err;

  logic            w_empty, w_full, w_push, w_pop;
  logic            w_retire, w_err_set;
  entry_t          w_head;
  logic [31:0]     w_rs1_data, w_rs2_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = in_vld && !w_full;
  assign w_head  = r_q[r_rd_ptr];

  // Operands see this cycle's write-back so a dependent op issued in the done cycle is correct.
  assign w_rs1_data = (w_head.rs1 == 5'd0) ? 32'd0 :
                      (wb_en && wb_rd == w_head.rs1) ? wb_data : r_regs[w_head.rs1];
  assign w_rs2_data = (w_head.rs2 == 5'd0) ? 32'd0 :
                      (wb_en && wb_rd == w_head.rs2) ? wb_data : r_regs[w_head.rs2];

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_retire    = 1'b0;
    w_err_set   = 1'b0;
    w_wdog_nxt  = r_wdog;
    case (r_state)
      S_IDLE: begin
        w_wdog_nxt = '0;
        if (done) w_err_set = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done) begin
          w_retire   = 1'b1;
          w_wdog_nxt = '0;
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = S_IDLE;
        end else if (r_wdog == WW'(TIMEOUT - 1)) begin
          // ALU never answered: drop the instruction uncounted.
          w_err_set   = 1'b1;
          w_wdog_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_wdog_nxt = r_wdog + WW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_q[r_wr_ptr] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, tag: in_tag};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wdog      <= '0;
      r_issue_vld <= 1'b0;
      r_issue_rd  <= '0;
      r_issue_tag <= '0;
      r_issue_rs1 <= '0;
      r_issue_rs2 <= '0;
      r_retired   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_wdog      <= w_wdog_nxt;
      r_issue_vld <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_issue_rd  <= w_head.rd;
        r_issue_tag <= w_head.tag;
        r_issue_rs1 <= w_rs1_data;
        r_issue_rs2 <= w_rs2_data;
      end
      if (w_retire)  r_retired <= r_retired + 32'd1;
      if (w_err_set) r_err     <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  assign in_rdy         = !w_full;
  assign busy           = !w_empty || (r_state == S_WAIT);
  assign issue_vld      = r_issue_vld;
  assign issue_rd       = r_issue_rd;
  assign issue_tag      = r_issue_tag;
  assign issue_rs1_data = r_issue_rs1;
  assign issue_rs2_data = r_issue_rs2;
  assign retired_count  = r_retired;
  assign err            = r_err;
  assign dbg_data       = (dbg_addr == 5'd0) ? 32'd0 : r_regs[dbg_addr];
endmodule

// File: tb/tb_riscv_exu_issue.sv
// Bench for riscv_exu_issue: ALU model with 1-cycle latency (result = rs1 + rs2 + alu_k),
// reference regfile feeding an issue scoreboard, table-driven single ops plus corner sequences.
module tb_riscv_exu_issue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clock, reset;
  logic        in_vld, in_rdy;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [7:0]  in_tag;
  logic        issue_vld;
  logic [4:0]  issue_rd;
  logic [7:0]  issue_tag;
  logic [31:0] issue_rs1_data, issue_rs2_data;
  logic        done, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy, err;
  logic [31:0] retired_count;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic        alu_done, alu_wb_en, alu_pend, alu_hold, alu_drop;
  logic [4:0]  alu_rd, p_rd;
  logic [31:0] alu_data, p_data, alu_k;
  logic        m_done, m_wb_en;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  assign done    = alu_done | m_done;
  assign wb_en   = alu_wb_en | m_wb_en;
  assign wb_rd   = m_wb_en ? m_rd : alu_rd;
  assign wb_data = m_wb_en ? m_data : alu_data;

  riscv_exu_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_tag(in_tag),
    .issue_vld(issue_vld), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .done(done), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .retired_count(retired_count), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  tag;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
  } sb_t;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  tag;
    logic [31:0] k;
    logic [31:0] exp;
    logic [31:0] cnt;
  } row_t;

  sb_t         sb [$];
  logic [31:0] mrf [32];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0, prev_cyc = 0, last_gap = 0;
  bit          have_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ALU model plus issue monitor; everything sampled and driven on the falling edge.
  initial begin
    alu_done = 0; alu_wb_en = 0; alu_rd = 0; alu_data = 0; alu_pend = 0;
    p_rd = 0; p_data = 0;
    forever begin
      @(negedge clock);
      cyc++;
      alu_done = 0; alu_wb_en = 0;
      if (alu_pend && alu_drop) alu_pend = 0;
      else if (alu_pend && !alu_hold) begin
        alu_done = 1; alu_wb_en = 1; alu_rd = p_rd; alu_data = p_data; alu_pend = 0;
      end
      if (issue_vld) begin
        if (have_prev) begin
          last_gap = cyc - prev_cyc;
          chk("issue_gap_ge2", {31'b0, last_gap >= 2}, 32'd1);
        end
        have_prev = 1; prev_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow actual=issue tag %0h required=no issue", issue_tag);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("issue_tag", {24'b0, issue_tag}, {24'b0, e.tag});
          chk("issue_rd", {27'b0, issue_rd}, {27'b0, e.rd});
          chk("issue_rs1", issue_rs1_data, e.op1);
          chk("issue_rs2", issue_rs2_data, e.op2);
        end
        alu_pend = 1; p_rd = issue_rd;
        p_data = issue_rs1_data + issue_rs2_data + alu_k;
      end
    end
  end

  // One-cycle offer; model state advances only if the bench expects acceptance.
  task automatic push(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic [7:0] t, input bit wr, input bit acc);
    sb_t e;
    in_vld = 1; in_rs1 = a; in_rs2 = b; in_rd = d; in_tag = t;
    chk("in_rdy", {31'b0, in_rdy}, {31'b0, acc});
    if (acc) begin
      e.tag = t; e.rd = d;
      e.op1 = (a == 0) ? 32'd0 : mrf[a];
      e.op2 = (b == 0) ? 32'd0 : mrf[b];
      sb.push_back(e);
      if (wr && d != 0) mrf[d] = e.op1 + e.op2 + alu_k;
    end
    @(negedge clock);
    in_vld = 0;
  endtask

  task automatic man_wb(input logic [4:0] d, input logic [31:0] v);
    m_wb_en = 1; m_rd = d; m_data = v;
    @(negedge clock);
    m_wb_en = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!busy && !alu_pend && !done) begin ok = 1; break; end
    end
    chk("drain", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    row_t rows [6];
    rows[0] = '{5'd0,  5'd0,  5'd5,  8'h01, 32'h0000_1234, 32'h0000_1234, 32'd1};
    rows[1] = '{5'd5,  5'd5,  5'd6,  8'h02, 32'h0000_0001, 32'h0000_2469, 32'd2};
    rows[2] = '{5'd6,  5'd5,  5'd31, 8'h03, 32'hFFFF_FFFF, 32'h0000_369C, 32'd3};
    rows[3] = '{5'd31, 5'd6,  5'd0,  8'h04, 32'h0000_0005, 32'h0000_0000, 32'd4};
    rows[4] = '{5'd0,  5'd31, 5'd1,  8'h05, 32'h8000_0000, 32'h8000_369C, 32'd5};
    rows[5] = '{5'd1,  5'd1,  5'd1,  8'h06, 32'h0000_0000, 32'h0000_6D38, 32'd6};

    for (int i = 0; i < 32; i++) mrf[i] = 0;
    reset = 1; in_vld = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_tag = 0;
    m_done = 0; m_wb_en = 0; m_rd = 0; m_data = 0; dbg_addr = 0;
    alu_hold = 0; alu_drop = 0; alu_k = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    chk("rst_in_rdy", {31'b0, in_rdy}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_issue_vld", {31'b0, issue_vld}, 32'd0);
    chk("rst_retired", retired_count, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);

    // Single ops from the table, run to completion one at a time.
    for (int r = 0; r < 6; r++) begin
      alu_k = rows[r].k;
      push(rows[r].rs1, rows[r].rs2, rows[r].rd, rows[r].tag, 1, 1);
      chk("lat_cycle1", {31'b0, issue_vld}, 32'd0);
      @(negedge clock);
      chk("lat_cycle2", {31'b0, issue_vld}, 32'd1);
      wait_idle();
      dbg_addr = rows[r].rd; #1;
      chk("row_dbg", dbg_data, rows[r].exp);
      chk("row_retired", retired_count, rows[r].cnt);
    end

    // Back-to-back dependency through the done-cycle bypass.
    man_wb(5'd1, 32'd7);
    mrf[1] = 32'd7;
    alu_k = 32'd9;
    push(5'd1, 5'd0, 5'd2, 8'h10, 1, 1);
    push(5'd2, 5'd1, 5'd3, 8'h11, 1, 1);
    wait_idle();
    chk("dep_gap", last_gap, 32'd2);
    dbg_addr = 5'd2; #1; chk("dep_x2", dbg_data, 32'h10);
    dbg_addr = 5'd3; #1; chk("dep_x3", dbg_data, 32'h20);
    chk("dep_retired", retired_count, 32'd8);

    // x0: write-back to x0 in the pop cycle must neither stick nor bypass.
    alu_k = 32'd3;
    push(5'd0, 5'd0, 5'd7, 8'h20, 1, 1);
    man_wb(5'd0, 32'hFFFF_FFFF);
    dbg_addr = 5'd0; #1; chk("x0_dbg", dbg_data, 32'd0);
    wait_idle();
    dbg_addr = 5'd7; #1; chk("x0_op_x7", dbg_data, 32'd3);
    chk("x0_retired", retired_count, 32'd9);

    // FIFO full with the ALU stalled: last offer is refused and never executed.
    alu_k = 32'd1;
    alu_hold = 1;
    for (int k = 0; k <= DEPTH + 1; k++)
      push(5'd7, 5'd0, 5'(8 + k), 8'(8'h30 + k), 1, k <= DEPTH);
    chk("full_busy", {31'b0, busy}, 32'd1);
    alu_hold = 0;
    wait_idle();
    chk("full_retired", retired_count, 32'(9 + DEPTH + 1));
    chk("full_sb_empty", sb.size(), 32'd0);
    chk("full_in_rdy", {31'b0, in_rdy}, 32'd1);
    dbg_addr = 5'(8 + DEPTH + 1); #1; chk("full_refused_rd", dbg_data, 32'd0);
    dbg_addr = 5'(8 + DEPTH); #1; chk("full_last_rd", dbg_data, 32'd4);

    // Watchdog: ALU swallows the issue.
    alu_drop = 1;
    push(5'd0, 5'd0, 5'd20, 8'h40, 0, 1);
    chk("to_err_pre", {31'b0, err}, 32'd0);
    @(negedge clock);
    chk("to_issue", {31'b0, issue_vld}, 32'd1);
    repeat (TIMEOUT - 1) @(negedge clock);
    chk("to_err_early", {31'b0, err}, 32'd0);
    @(negedge clock);
    chk("to_err", {31'b0, err}, 32'd1);
    chk("to_busy", {31'b0, busy}, 32'd0);
    chk("to_retired", retired_count, 32'(9 + DEPTH + 1));
    dbg_addr = 5'd20; #1; chk("to_no_write", dbg_data, 32'd0);
    alu_drop = 0;
    alu_k = 32'd2;
    push(5'd7, 5'd0, 5'd21, 8'h41, 1, 1);
    @(negedge clock);
    chk("to_next_issue", {31'b0, issue_vld}, 32'd1);
    wait_idle();
    dbg_addr = 5'd21; #1; chk("to_next_x21", dbg_data, 32'd5);
    chk("to_next_retired", retired_count, 32'(9 + DEPTH + 2));
    chk("to_err_sticky", {31'b0, err}, 32'd1);

    // Reset with one op in flight and three queued.
    alu_hold = 1;
    for (int k = 0; k < 4; k++) push(5'd7, 5'd0, 5'(22 + k), 8'(8'h50 + k), 1, 1);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    reset = 1; alu_drop = 1;
    @(negedge clock);
    reset = 0;
    sb.delete();
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_in_rdy", {31'b0, in_rdy}, 32'd1);
    chk("mr_issue_vld", {31'b0, issue_vld}, 32'd0);
    chk("mr_issue_rd", {27'b0, issue_rd}, 32'd0);
    chk("mr_issue_tag", {24'b0, issue_tag}, 32'd0);
    chk("mr_issue_rs1", issue_rs1_data, 32'd0);
    chk("mr_issue_rs2", issue_rs2_data, 32'd0);
    chk("mr_retired", retired_count, 32'd0);
    chk("mr_err", {31'b0, err}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      chk("mr_regfile", dbg_data, 32'd0);
      @(negedge clock);
    end
    m_done = 1;
    @(negedge clock);
    m_done = 0;
    chk("stray_done_err", {31'b0, err}, 32'd1);
    chk("stray_done_retired", retired_count, 32'd0);
    alu_hold = 0; alu_drop = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
